// File: rtl/inv_pipe_pkg.sv
// Shared helpers for the inv_pipe retimed bus inverter.
// Defining INV_PIPE_PARITY_EN adds an even-parity bit to every stage payload.
package inv_pipe_pkg;

`ifdef INV_PIPE_PARITY_EN
    localparam int INV_PIPE_PAR_W = 1;
`else
    localparam int INV_PIPE_PAR_W = 0;
`endif

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Flat width of one stage payload: data plus the optional parity bit.
    function automatic int payload_w(input int width);
        return width + INV_PIPE_PAR_W;
    endfunction

endpackage

// File: rtl/inv_pipe_stage.sv
// One valid/data register pair of the inv_pipe skid-free pipeline.
module inv_pipe_stage
    import inv_pipe_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    input  logic [PW-1:0] up_data,
    input  logic          dn_ready,
    output logic          rdy,
    output logic          valid,
    output logic [PW-1:0] data
);

    assign rdy = ~valid | dn_ready;

    // Data only moves with a valid beat so nq stays put across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (rdy) begin
            valid <= up_valid;
            if (up_valid)
                data <= up_data;
        end
    end

endmodule

// File: rtl/inv_pipe.sv
// DEPTH-stage registered masked inverter with valid/ready flow control.
// Optional INV_PIPE_PARITY_EN adds nq_par = ^nq, carried alongside each beat.
module inv_pipe
    import inv_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [WIDTH-1:0]         i,
    input  logic [WIDTH-1:0]         inv_mask,
    output logic                     nq_valid,
    input  logic                     nq_ready,
    output logic [WIDTH-1:0]         nq,
    output logic [occ_w(DEPTH)-1:0]  occ
`ifdef INV_PIPE_PARITY_EN
    ,
    output logic                     nq_par
`endif
);

    localparam int OCC_W = occ_w(DEPTH);
    localparam int PW    = payload_w(WIDTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("inv_pipe: DEPTH must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("inv_pipe: WIDTH must be >= 1");
    end

`ifdef INV_PIPE_PARITY_EN
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             par;
    } beat_t;
`else
    typedef struct packed {
        logic [WIDTH-1:0] data;
    } beat_t;
`endif

    beat_t              in_beat;
    beat_t [DEPTH:0]    dat_pipe;
    logic  [DEPTH:0]    vld_pipe;
    logic  [DEPTH-1:0]  rdy_dn;
    logic  [DEPTH-1:0]  stg_rdy;
    logic               unused_stg_rdy;
    logic               push;
    logic               pop;

    always_comb begin
        in_beat      = '0;
        in_beat.data = i ^ inv_mask;
`ifdef INV_PIPE_PARITY_EN
        in_beat.par  = ^(i ^ inv_mask);
`endif
    end

    assign vld_pipe[0] = i_valid;
    assign dat_pipe[0] = in_beat;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        // Downstream ready flattened to an OR over later empty stages; it is
        // the unrolled ready chain and keeps the net free of bit self-loops.
        if (k == DEPTH - 1) begin : g_last
            assign rdy_dn[k] = nq_ready;
        end else begin : g_mid
            assign rdy_dn[k] = nq_ready | ~(&vld_pipe[DEPTH:k+2]);
        end

        inv_pipe_stage #(.PW(PW)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (vld_pipe[k]),
            .up_data  (dat_pipe[k]),
            .dn_ready (rdy_dn[k]),
            .rdy      (stg_rdy[k]),
            .valid    (vld_pipe[k+1]),
            .data     (dat_pipe[k+1])
        );
    end

    // Later stage ready outputs duplicate rdy_dn; only stage 0 is consumed.
    assign unused_stg_rdy = ^stg_rdy;
    assign i_ready        = stg_rdy[0];

    assign nq_valid = vld_pipe[DEPTH];
    assign nq       = dat_pipe[DEPTH].data;
`ifdef INV_PIPE_PARITY_EN
    assign nq_par   = dat_pipe[DEPTH].par;
`endif

    assign push = i_valid & i_ready;
    assign pop  = nq_valid & nq_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_pipe.sv
// Directed-vector and scoreboard bench for inv_pipe (WIDTH=8, DEPTH=2).
module tb_inv_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int NRAND = 1000;

    logic             clk;
    logic             rst;
    logic             i_valid;
    logic             i_ready;
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] inv_mask;
    logic             nq_valid;
    logic             nq_ready;
    logic [WIDTH-1:0] nq;
    logic [OCC_W-1:0] occ;
`ifdef INV_PIPE_PARITY_EN
    logic             nq_par;
`endif

    int total = 0;
    int bad   = 0;
    int sent;
    int cyc;
    logic acc;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] hd;

    typedef struct {
        logic [WIDTH-1:0] i;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] exp;
        logic             par;
    } vec_t;
    vec_t vec[8];

    inv_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i        (i),
        .inv_mask (inv_mask),
        .nq_valid (nq_valid),
        .nq_ready (nq_ready),
        .nq       (nq),
        .occ      (occ)
`ifdef INV_PIPE_PARITY_EN
        ,
        .nq_par   (nq_par)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: in-flight beats, order, occupancy and parity, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check("occ_vs_sb", 32'(occ), 32'(exp_q.size()));
`ifdef INV_PIPE_PARITY_EN
            if (nq_valid)
                check("nq_par_eq_xor", 32'(nq_par), 32'(^nq));
`endif
            if (nq_valid && nq_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_empty_sb: got %0h expected no beat", nq);
                end else begin
                    hd = exp_q.pop_front();
                    check("nq_order", 32'(nq), 32'(hd));
`ifdef INV_PIPE_PARITY_EN
                    check("nq_par_sb", 32'(nq_par), 32'(^hd));
`endif
                end
            end
            if (i_valid && i_ready)
                exp_q.push_back(i ^ inv_mask);
        end
    end

    initial begin
        rst      = 1'b1;
        i_valid  = 1'b0;
        i        = '0;
        inv_mask = '0;
        nq_ready = 1'b1;

        vec[0] = '{8'hA5, 8'hFF, 8'h5A, 1'b0};
        vec[1] = '{8'hF0, 8'h0F, 8'hFF, 1'b0};
        vec[2] = '{8'h3C, 8'h00, 8'h3C, 1'b0};
        vec[3] = '{8'h00, 8'h07, 8'h07, 1'b1};
        vec[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vec[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vec[6] = '{8'h81, 8'h80, 8'h01, 1'b1};
        vec[7] = '{8'hC3, 8'h5A, 8'h99, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_nq_valid", 32'(nq_valid), 0);
        check("rst_nq", 32'(nq), 0);
        check("rst_occ", 32'(occ), 0);
        check("rst_i_ready", 32'(i_ready), 1);
        tick();
        rst = 1'b0;

        // Single beats: latency exactly DEPTH edges including the accepting one
        foreach (vec[n]) begin
            i        = vec[n].i;
            inv_mask = vec[n].mask;
            i_valid  = 1'b1;
            @(negedge clk);
            check("tbl_i_ready", 32'(i_ready), 1);
            tick();
            i_valid = 1'b0;
            @(negedge clk);
            check("tbl_early_valid", 32'(nq_valid), 0);
            tick();
            @(negedge clk);
            check("tbl_nq_valid", 32'(nq_valid), 1);
            check("tbl_nq", 32'(nq), 32'(vec[n].exp));
`ifdef INV_PIPE_PARITY_EN
            check("tbl_nq_par", 32'(nq_par), 32'(vec[n].par));
`endif
            tick();
        end

        // Backpressure: third beat held until the consumer drains
        nq_ready = 1'b0;
        inv_mask = 8'hFF;
        i        = 8'h01;
        i_valid  = 1'b1;
        tick();
        i = 8'h02;
        tick();
        i = 8'h03;
        @(negedge clk);
        check("bp_occ_full", 32'(occ), 2);
        check("bp_i_ready", 32'(i_ready), 0);
        check("bp_nq_valid", 32'(nq_valid), 1);
        check("bp_nq", 32'(nq), 32'h FE);
        tick();
        tick();
        @(negedge clk);
        check("bp_hold_occ", 32'(occ), 2);
        check("bp_hold_nq", 32'(nq), 32'h FE);
        check("bp_hold_valid", 32'(nq_valid), 1);
        tick();
        nq_ready = 1'b1;
        @(negedge clk);
        check("bp_out0", 32'(nq), 32'h FE);
        tick();
        i_valid = 1'b0;
        @(negedge clk);
        check("bp_out1", 32'(nq), 32'h FD);
        tick();
        @(negedge clk);
        check("bp_out2", 32'(nq), 32'h FC);
        check("bp_out2_valid", 32'(nq_valid), 1);
        tick();
        @(negedge clk);
        check("bp_drained_valid", 32'(nq_valid), 0);
        check("bp_drained_occ", 32'(occ), 0);

        // Full pipeline with simultaneous push and pop every cycle
        tick();
        nq_ready = 1'b0;
        inv_mask = 8'h55;
        i        = 8'h10;
        i_valid  = 1'b1;
        tick();
        i = 8'h11;
        tick();
        nq_ready = 1'b1;
        i        = 8'h12;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("full_occ", 32'(occ), 2);
            check("full_nq_valid", 32'(nq_valid), 1);
            check("full_i_ready", 32'(i_ready), 1);
            tick();
            i = 8'(19 + c);
        end
        i_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("full_drain_occ", 32'(occ), 0);

        // Asynchronous reset with two beats in flight
        tick();
        nq_ready = 1'b0;
        inv_mask = 8'hFF;
        i        = 8'h11;
        i_valid  = 1'b1;
        tick();
        i = 8'h22;
        tick();
        i_valid = 1'b0;
        @(negedge clk);
        check("arst_pre_occ", 32'(occ), 2);
        check("arst_pre_ready", 32'(i_ready), 0);
        #2 rst = 1'b1;
        #1;
        check("arst_nq_valid", 32'(nq_valid), 0);
        check("arst_nq", 32'(nq), 0);
        check("arst_occ", 32'(occ), 0);
        check("arst_i_ready", 32'(i_ready), 1);
        @(negedge clk);
        tick();
        rst      = 1'b0;
        nq_ready = 1'b1;

        // Random traffic with random stalls, checked by the scoreboard
        sent = 0;
        cyc  = 0;
        while ((sent < NRAND) && (cyc < 20000)) begin
            @(negedge clk);
            acc = i_valid && i_ready;
            tick();
            cyc++;
            if (acc)
                sent++;
            if (acc || !i_valid) begin
                i_valid  = (sent < NRAND) && ($urandom_range(9) < 7);
                i        = 8'($urandom);
                inv_mask = 8'($urandom);
            end
            nq_ready = ($urandom_range(9) < 6);
        end
        check("rand_sent", 32'(sent), 32'(NRAND));
        i_valid  = 1'b0;
        nq_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        @(negedge clk);
        check("rand_end_occ", 32'(occ), 0);
        check("rand_end_valid", 32'(nq_valid), 0);
        check("rand_end_sb", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
